// File: rtl/tx_8b10b_encoder_if.sv
// Byte-side bus of the 8b/10b TX encoder. Upstream is the master and the encoder is the slave.
// Symbol, disparity and status flow back to the master.
interface tx_8b10b_encoder_if;
    logic [7:0] data_in;
    logic       k_in;
    logic       valid_in;
    logic       ready;
    logic       force_realign;
    logic [9:0] symbol_out;
    logic       rd_out;
    logic       aligned;
    logic       code_err;

    modport master (
        output data_in, k_in, valid_in, force_realign,
        input  ready, symbol_out, rd_out, aligned, code_err
    );

    modport slave (
        input  data_in, k_in, valid_in, force_realign,
        output ready, symbol_out, rd_out, aligned, code_err
    );
endinterface

// File: rtl/tx_8b10b_encoder.sv
// 8b/10b encoder producing one symbol per clk_byte for the DDR serializer.
// After reset or a realign request it sends a K28.5 comma burst, and it fills idle slots with K28.5.
module tx_8b10b_encoder #(
    parameter int unsigned ALIGN_COMMAS = 16
) (
    input  logic               clk_byte,
    input  logic               rst,
    tx_8b10b_encoder_if.slave  bus
);
    localparam logic [7:0] K28_5      = 8'hBC;
    localparam logic [9:0] K28_5_RDM  = 10'h17C;
    localparam logic [7:0] LAST_COUNT = 8'(ALIGN_COMMAS - 1);

    typedef enum logic {ST_ALIGN = 1'b0, ST_RUN = 1'b1} state_t;

    state_t     state_q;
    logic [7:0] count_q;
    logic [9:0] symbol_q;
    logic       rd_q;
    logic       code_err_q;

    logic [7:0] enc_byte;
    logic       enc_k;
    logic       code_err_d;
    logic [4:0] x;
    logic [2:0] y;
    logic [5:0] code6_base;
    logic [5:0] code6;
    logic [3:0] code4_base;
    logic [3:0] code4;
    logic       bal6;
    logic       bal4;
    logic       rd_mid;
    logic       alt7;
    logic       rd_d;
    logic [9:0] symbol_d;

    // The tables hold the RD- form as abcdei / fghj. The RD+ form is derived from it below.
    function automatic logic [5:0] d6_rdm(input logic [4:0] xv);
        logic [5:0] c;
        case (xv)
            5'd0:  c = 6'b100111;  5'd1:  c = 6'b011101;
            5'd2:  c = 6'b101101;  5'd3:  c = 6'b110001;
            5'd4:  c = 6'b110101;  5'd5:  c = 6'b101001;
            5'd6:  c = 6'b011001;  5'd7:  c = 6'b111000;
            5'd8:  c = 6'b111001;  5'd9:  c = 6'b100101;
            5'd10: c = 6'b010101;  5'd11: c = 6'b110100;
            5'd12: c = 6'b001101;  5'd13: c = 6'b101100;
            5'd14: c = 6'b011100;  5'd15: c = 6'b010111;
            5'd16: c = 6'b011011;  5'd17: c = 6'b100011;
            5'd18: c = 6'b010011;  5'd19: c = 6'b110010;
            5'd20: c = 6'b001011;  5'd21: c = 6'b101010;
            5'd22: c = 6'b011010;  5'd23: c = 6'b111010;
            5'd24: c = 6'b110011;  5'd25: c = 6'b100110;
            5'd26: c = 6'b010110;  5'd27: c = 6'b110110;
            5'd28: c = 6'b001110;  5'd29: c = 6'b101110;
            5'd30: c = 6'b011110;  default: c = 6'b101011;
        endcase
        return c;
    endfunction

    function automatic logic [3:0] d4_rdm(input logic [2:0] yv, input logic alt);
        logic [3:0] c;
        case (yv)
            3'd0: c = 4'b1011;
            3'd1: c = 4'b1001;
            3'd2: c = 4'b0101;
            3'd3: c = 4'b1100;
            3'd4: c = 4'b1101;
            3'd5: c = 4'b1010;
            3'd6: c = 4'b0110;
            default: c = alt ? 4'b0111 : 4'b1110;
        endcase
        return c;
    endfunction

    function automatic logic [3:0] k4_rdm(input logic [2:0] yv);
        logic [3:0] c;
        case (yv)
            3'd0: c = 4'b1011;
            3'd1: c = 4'b0110;
            3'd2: c = 4'b1010;
            3'd3: c = 4'b1100;
            3'd4: c = 4'b1101;
            3'd5: c = 4'b0101;
            3'd6: c = 4'b1001;
            default: c = 4'b0111;
        endcase
        return c;
    endfunction

    function automatic logic k_code_ok(input logic [7:0] b);
        return (b[4:0] == 5'd28) ||
               ((b[7:5] == 3'd7) && ((b[4:0] == 5'd23) || (b[4:0] == 5'd27) ||
                                     (b[4:0] == 5'd29) || (b[4:0] == 5'd30)));
    endfunction

    assign bus.ready      = (state_q == ST_RUN) && !bus.force_realign;
    assign bus.symbol_out = symbol_q;
    assign bus.rd_out     = rd_q;
    assign bus.aligned    = (state_q == ST_RUN);
    assign bus.code_err   = code_err_q;

    // Anything not accepted becomes K28.5. This covers ALIGN, idle and rejected K codes.
    always_comb begin
        enc_byte   = K28_5;
        enc_k      = 1'b1;
        code_err_d = 1'b0;
        if (bus.ready && bus.valid_in) begin
            if (bus.k_in && !k_code_ok(bus.data_in)) begin
                code_err_d = 1'b1;
            end else begin
                enc_byte = bus.data_in;
                enc_k    = bus.k_in;
            end
        end
    end

    always_comb begin
        x          = enc_byte[4:0];
        y          = enc_byte[7:5];
        code6_base = (enc_k && (x == 5'd28)) ? 6'b001111 : d6_rdm(x);
        bal6       = ($countones(code6_base) == 3);
        // D.7 is the only balanced 6b code whose form depends on RD.
        code6      = (rd_q && (!bal6 || (x == 5'd7))) ? ~code6_base : code6_base;
        rd_mid     = bal6 ? rd_q : ~rd_q;
        alt7       = (!rd_mid && ((x == 5'd17) || (x == 5'd18) || (x == 5'd20))) ||
                     ( rd_mid && ((x == 5'd11) || (x == 5'd13) || (x == 5'd14)));
        code4_base = enc_k ? k4_rdm(y) : d4_rdm(y, alt7);
        bal4       = ($countones(code4_base) == 2);
        code4      = (rd_mid && (enc_k || !bal4 || (y == 3'd3))) ? ~code4_base : code4_base;
        rd_d       = bal4 ? rd_mid : ~rd_mid;
        symbol_d   = {code4[0], code4[1], code4[2], code4[3],
                      code6[0], code6[1], code6[2], code6[3], code6[4], code6[5]};
    end

    always_ff @(posedge clk_byte or posedge rst) begin
        if (rst) begin
            state_q    <= ST_ALIGN;
            count_q    <= 8'd1;
            symbol_q   <= K28_5_RDM;
            rd_q       <= 1'b1;
            code_err_q <= 1'b0;
        end else begin
            symbol_q   <= symbol_d;
            rd_q       <= rd_d;
            code_err_q <= code_err_d;
            if (bus.force_realign) begin
                state_q <= ST_ALIGN;
                count_q <= 8'd1;
            end else if (state_q == ST_ALIGN) begin
                count_q <= count_q + 8'd1;
                if (count_q == LAST_COUNT) begin
                    state_q <= ST_RUN;
                end
            end
        end
    end
endmodule

// File: tb/tb_tx_8b10b_encoder.sv
// Scoreboard bench for tx_8b10b_encoder. A table-driven reference model predicts each symbol.
// The model state tracks the expected RD and the expected alignment state.
`timescale 1ns/1ps
module tb_tx_8b10b_encoder;
    localparam int NCOMMA = 4;

    logic clk_byte = 1'b0;
    logic rst      = 1'b1;
    always #5 clk_byte = ~clk_byte;

    tx_8b10b_encoder_if bus();

    tx_8b10b_encoder #(.ALIGN_COMMAS(NCOMMA)) dut (
        .clk_byte (clk_byte),
        .rst      (rst),
        .bus      (bus)
    );

    typedef struct packed {
        logic [9:0] sym;
        logic       rd;
        logic       err;
        logic       al;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   txn    = 0;
    logic m_rd   = 1'b1;
    logic m_run  = 1'b0;
    int   m_cnt  = 1;
    logic [9:0] last_sym;
    logic       last_rd;
    logic track_en = 1'b0;
    logic run_bit  = 1'b0;
    int   run_len  = 0;

    // Golden 6b tables (abcdei), both RD columns.
    logic [5:0] d6_m [32] = '{
        6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
        6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
        6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
        6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
    logic [5:0] d6_p [32] = '{
        6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001, 6'b011001, 6'b000111,
        6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b101000,
        6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
        6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001, 6'b100001, 6'b010100};
    // Golden 4b tables (fghj); index 7 of the D table is the primary P7 form.
    logic [3:0] d4_m [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
    logic [3:0] d4_p [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b0001};
    logic [3:0] k4_m [8] = '{4'b1011, 4'b0110, 4'b1010, 4'b1100, 4'b1101, 4'b0101, 4'b1001, 4'b0111};
    logic [3:0] k4_p [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b1000};
    logic [7:0] klist [12] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
                               8'hF7, 8'hFB, 8'hFD, 8'hFE};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (txn %0d)", tag, got, exp, txn);
        end
    endtask

    function automatic logic k_valid(input logic [7:0] d);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (klist[i] == d) hit = 1'b1;
        end
        return hit;
    endfunction

    function automatic void model(input logic [7:0] d, input logic k, input logic rd,
                                  output logic [9:0] sym, output logic rd_o);
        logic [4:0] xv;
        logic [2:0] yv;
        logic [5:0] s6;
        logic [3:0] s4;
        logic       rdm;
        xv = d[4:0];
        yv = d[7:5];
        if (k && xv == 5'd28) s6 = rd ? 6'b110000 : 6'b001111;
        else                  s6 = rd ? d6_p[xv] : d6_m[xv];
        rdm = ($countones(s6) != 3) ? ~rd : rd;
        if (k)
            s4 = rdm ? k4_p[yv] : k4_m[yv];
        else if (yv == 3'd7 && ((!rdm && (xv == 5'd17 || xv == 5'd18 || xv == 5'd20)) ||
                                ( rdm && (xv == 5'd11 || xv == 5'd13 || xv == 5'd14))))
            s4 = rdm ? 4'b1000 : 4'b0111;
        else
            s4 = rdm ? d4_p[yv] : d4_m[yv];
        rd_o = ($countones(s4) != 2) ? ~rdm : rdm;
        sym  = {s4[0], s4[1], s4[2], s4[3], s6[0], s6[1], s6[2], s6[3], s6[4], s6[5]};
    endfunction

    // Drives one cycle of stimulus, predicts the result, then compares after the edge.
    task automatic step(input logic v, input logic k, input logic [7:0] d, input logic fr);
        exp_t       e;
        exp_t       o;
        logic       acc;
        logic [9:0] s;
        logic       r;
        int         maxr;
        int         ones;
        bus.valid_in      = v;
        bus.k_in          = k;
        bus.data_in       = d;
        bus.force_realign = fr;
        #1;
        check("ready", 32'(bus.ready), 32'(m_run && !fr));
        acc = v && m_run && !fr;
        if (acc && (!k || k_valid(d))) model(d, k, m_rd, s, r);
        else                           model(8'hBC, 1'b1, m_rd, s, r);
        e.sym = s;
        e.rd  = r;
        e.err = acc && k && !k_valid(d);
        if (fr) begin
            m_run = 1'b0;
            m_cnt = 1;
        end else if (!m_run) begin
            m_cnt++;
            if (m_cnt == NCOMMA) m_run = 1'b1;
        end
        e.al = m_run;
        m_rd = r;
        sb_q.push_back(e);
        @(posedge clk_byte);
        #1;
        o = sb_q.pop_front();
        check("symbol", 32'(bus.symbol_out), 32'(o.sym));
        check("rd_out", 32'(bus.rd_out), 32'(o.rd));
        check("code_err", 32'(bus.code_err), 32'(o.err));
        check("aligned", 32'(bus.aligned), 32'(o.al));
        last_sym = bus.symbol_out;
        last_rd  = bus.rd_out;
        if (track_en) begin
            maxr = 0;
            for (int i = 0; i < 10; i++) begin
                if (run_len != 0 && bus.symbol_out[i] == run_bit) begin
                    run_len++;
                end else begin
                    run_bit = bus.symbol_out[i];
                    run_len = 1;
                end
                if (run_len > maxr) maxr = run_len;
            end
            ones = $countones(bus.symbol_out);
            check("run_len_le5", 32'(maxr <= 5), 32'd1);
            check("disparity", 32'(ones >= 4 && ones <= 6), 32'd1);
        end
        $display("txn %0d v=%b k=%b d=%h fr=%b -> sym=%h rd=%b err=%b al=%b",
                 txn, v, k, d, fr, bus.symbol_out, bus.rd_out, bus.code_err, bus.aligned);
        txn++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [9:0] exp_idle;
        bus.valid_in      = 1'b0;
        bus.k_in          = 1'b0;
        bus.data_in       = 8'h00;
        bus.force_realign = 1'b0;

        // Reset values while rst is held.
        repeat (2) @(posedge clk_byte);
        #1;
        check("rst_symbol", 32'(bus.symbol_out), 32'h17C);
        check("rst_rd", 32'(bus.rd_out), 32'd1);
        check("rst_err", 32'(bus.code_err), 32'd0);
        check("rst_ready", 32'(bus.ready), 32'd0);
        check("rst_aligned", 32'(bus.aligned), 32'd0);
        @(negedge clk_byte);
        rst = 1'b0;

        // Alignment burst after reset.
        step(1'b0, 1'b0, 8'h00, 1'b0);
        check("t1_comma2", 32'(last_sym), 32'h283);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        check("t1_comma3", 32'(last_sym), 32'h17C);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        check("t1_comma4", 32'(last_sym), 32'h283);
        check("t1_rd", 32'(last_rd), 32'd0);

        // First data at RD-.
        step(1'b1, 1'b0, 8'h00, 1'b0);
        check("t2_d0_0", 32'(last_sym), 32'h0B9);
        check("t2_d0_0_rd", 32'(last_rd), 32'd0);
        step(1'b1, 1'b0, 8'hB5, 1'b0);
        check("t2_d21_5", 32'(last_sym), 32'h155);
        check("t2_d21_5_rd", 32'(last_rd), 32'd0);

        // Idle commas alternate with RD.
        exp_idle = 10'h17C;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, 8'h00, 1'b0);
            check("t3_idle", 32'(last_sym), 32'(exp_idle));
            exp_idle = (exp_idle == 10'h17C) ? 10'h283 : 10'h17C;
        end

        // Invalid K code is replaced by K28.5 and flagged for one cycle.
        step(1'b1, 1'b1, 8'h00, 1'b0);
        check("t4_sym", 32'(last_sym), 32'h17C);
        check("t4_rd", 32'(last_rd), 32'd1);
        check("t4_err", 32'(bus.code_err), 32'd1);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        check("t4_err_clear", 32'(bus.code_err), 32'd0);

        // Realign mid-stream, including a held request.
        step(1'b1, 1'b0, 8'h55, 1'b0);
        step(1'b1, 1'b0, 8'h66, 1'b1);
        step(1'b1, 1'b0, 8'h66, 1'b1);
        for (int i = 0; i < NCOMMA - 1; i++) step(1'b1, 1'b0, 8'h66, 1'b0);
        step(1'b1, 1'b0, 8'h66, 1'b0);
        step(1'b1, 1'b1, 8'hBC, 1'b0);

        // Asynchronous reset mid-stream.
        #2;
        bus.valid_in = 1'b1;
        bus.data_in  = 8'h3A;
        rst = 1'b1;
        #1;
        check("t5_rst_symbol", 32'(bus.symbol_out), 32'h17C);
        check("t5_rst_rd", 32'(bus.rd_out), 32'd1);
        check("t5_rst_ready", 32'(bus.ready), 32'd0);
        check("t5_rst_aligned", 32'(bus.aligned), 32'd0);
        @(negedge clk_byte);
        rst   = 1'b0;
        m_rd  = 1'b1;
        m_run = 1'b0;
        m_cnt = 1;
        for (int i = 0; i < NCOMMA - 1; i++) step(1'b1, 1'b0, 8'h3A, 1'b0);
        step(1'b1, 1'b0, 8'h3A, 1'b0);

        // Full sweep of D and K codes at both RDs.
        track_en = 1'b1;
        run_len  = 0;
        for (int c = 0; c < 256; c++) begin
            for (int t = 0; t < 2; t++) begin
                if (m_rd != 1'(t)) step(1'b0, 1'b0, 8'h00, 1'b0);
                step(1'b1, 1'b0, 8'(c), 1'b0);
            end
        end
        for (int c = 0; c < 12; c++) begin
            for (int t = 0; t < 2; t++) begin
                if (m_rd != 1'(t)) step(1'b0, 1'b0, 8'h00, 1'b0);
                step(1'b1, 1'b1, klist[c], 1'b0);
            end
        end
        track_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
